// File: rtl/uart_pkg.sv
// Shared FSM state type and default parameters for the UART transmit scheduler.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_DONE,
        ST_DRAIN
    } sched_state_e;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_TIMEOUT_CYCLES = 20000;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin picker: first set req bit above last_winner, wrapping.
module uart_rr_arbiter
    import uart_pkg::*;
#(
    parameter int  NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_winner,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   index,
    output logic               any
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        pick     = '0;
        index    = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand     = (32'(last_winner) + off) % NUM_REQ;
            cand_idx = cand[IDX_W-1:0];
            if (!any && req[cand_idx]) begin
                any   = 1'b1;
                index = cand_idx;
            end
        end
        if (any) begin
            pick[index] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler feeding one requester's byte at a time to a shared uart_tx.
// The done_tx watchdog is built only when UART_SCHED_TIMEOUT_EN is defined.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int  NUM_REQ        = DEF_NUM_REQ,
    parameter int  TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 tx_start,
    output logic [7:0]           tx_data_out,
    input  logic                 tx_active,
    input  logic                 done_tx,
    output logic                 busy,
    output logic                 timeout_err
);

    sched_state_e       state, state_nxt;
    logic [IDX_W-1:0]   last_winner, win_idx, arb_idx;
    logic [NUM_REQ-1:0] win_onehot, arb_pick;
    logic               arb_any;
    logic               wd_expire;

    uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (req),
        .last_winner(last_winner),
        .pick       (arb_pick),
        .index      (arb_idx),
        .any        (arb_any)
    );

`ifdef UART_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] watchdog;

    // Expiry is decided on the last WAIT_DONE cycle so the pulse lands as DRAIN starts.
    assign wd_expire = (state == ST_WAIT_DONE) && (watchdog == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            watchdog    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= wd_expire && !done_tx;
            if (state == ST_LAUNCH) begin
                watchdog <= '0;
            end else if (state == ST_WAIT_DONE) begin
                watchdog <= watchdog + WD_W'(1);
            end
        end
    end
`else
    assign wd_expire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tx_start  = 1'b0;
        gnt       = '0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (arb_any) state_nxt = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                tx_start  = 1'b1;
                gnt       = win_onehot;
                state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (done_tx || wd_expire) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Wait for done_tx to drop so a held completion cannot retrigger a launch.
                if (!done_tx && !tx_active) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_winner <= IDX_W'(NUM_REQ - 1);
            win_idx     <= '0;
            win_onehot  <= '0;
            tx_data_out <= '0;
        end else begin
            if (state == ST_IDLE && arb_any) begin
                win_idx     <= arb_idx;
                win_onehot  <= arb_pick;
                tx_data_out <= req_data[8*arb_idx +: 8];
            end
            if (state == ST_WAIT_DONE && state_nxt == ST_DRAIN) begin
                last_winner <= win_idx;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomised bench for uart_tx_scheduler with a transaction-level reference model
// and a scripted transmitter responder; directed cases pin the model to literals.
module tb_uart_tx_scheduler;

    localparam int N = 4;
    localparam int T = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_data = '0;
    logic           tx_active = 1'b0;
    logic           done_tx = 1'b0;
    logic [N-1:0]   gnt;
    logic           tx_start;
    logic [7:0]     tx_data_out;
    logic           busy;
    logic           timeout_err;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .tx_start   (tx_start),
        .tx_data_out(tx_data_out),
        .tx_active  (tx_active),
        .done_tx    (done_tx),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: where the single outstanding byte is in its life cycle.
    localparam int M_FREE = 0, M_START = 1, M_INFLIGHT = 2, M_SETTLE = 3;
    int         m_phase = M_FREE;
    int         m_last = N - 1;
    int         m_win = 0;
    int         m_cyc = 0;
    int         m_wait_from = 0;
    logic [7:0] m_data = '0;
    logic       m_to = 1'b0;

    function automatic int rr_next(input logic [N-1:0] r, input int last);
        logic [N-1:0] sh;
        for (int k = 1; k <= N; k++) begin
            sh = r >> ((last + k) % N);
            if (sh[0]) return (last + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        m_cyc++;
        m_to = 1'b0;
        if (!rst) begin
            m_phase = M_FREE;
            m_last  = N - 1;
            m_data  = '0;
        end else begin
            case (m_phase)
                M_FREE: if (req != '0) begin
                    m_win   = rr_next(req, m_last);
                    m_data  = req_data[8*m_win +: 8];
                    m_phase = M_START;
                end
                M_START: begin
                    m_phase     = M_INFLIGHT;
                    m_wait_from = m_cyc;
                end
                M_INFLIGHT: begin
                    if (done_tx) begin
                        m_phase = M_SETTLE;
                        m_last  = m_win;
                    end
`ifdef UART_SCHED_TIMEOUT_EN
                    else if (m_cyc - m_wait_from == T) begin
                        m_to    = 1'b1;
                        m_phase = M_SETTLE;
                        m_last  = m_win;
                    end
`endif
                end
                M_SETTLE: if (!done_tx && !tx_active) m_phase = M_FREE;
                default: m_phase = M_FREE;
            endcase
        end
        #1;
        check("tx_start", tx_start, (m_phase == M_START));
        check("gnt", gnt, (m_phase == M_START) ? (N'(1) << m_win) : '0);
        check("busy", busy, (m_phase != M_FREE));
        check("tx_data_out", tx_data_out, m_data);
        check("timeout_err", timeout_err, m_to);
    end

    // Transmitter responder: 0 = random frame timing, 1 = dead, 2 = fixed long done_tx.
    int   x_mode = 0;
    int   x_act = 0, x_done = 0, x_tail = 0;
    logic x_overlap = 1'b0;

    task automatic xmt_clear();
        x_act = 0; x_done = 0; x_tail = 0;
        tx_active = 1'b0; done_tx = 1'b0;
    endtask

    task automatic xmt_update();
        if (tx_start) begin
            case (x_mode)
                1: begin x_act = 0; x_done = 0; x_tail = 0; end
                2: begin x_act = 1; x_done = 5; x_tail = 2; x_overlap = 1'b0; end
                default: begin
                    x_act     = $urandom_range(4, 1);
                    x_done    = $urandom_range(5, 1);
                    x_tail    = $urandom_range(3, 0);
                    x_overlap = 1'($urandom_range(1, 0));
                end
            endcase
        end
        if (x_act > 0) begin
            tx_active = 1'b1; done_tx = 1'b0; x_act--;
        end else if (x_done > 0) begin
            done_tx = 1'b1; tx_active = x_overlap; x_done--;
        end else if (x_tail > 0) begin
            done_tx = 1'b0; tx_active = 1'b1; x_tail--;
        end else begin
            done_tx = 1'b0; tx_active = 1'b0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        xmt_update();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            cycle();
            n++;
        end
        check(name, busy, 1'b0);
    endtask

    task automatic wait_launch(input string name);
        int n = 0;
        while (tx_start !== 1'b1 && n < 8) begin
            cycle();
            n++;
        end
        check(name, tx_start, 1'b1);
    endtask

    initial begin
        logic [7:0] seen[$];
        logic [7:0] order[5];
        logic [N-1:0] nr;
        int starts, d, hi, to, first, pulses;

        repeat (2) cycle();
        check("rst_busy", busy, 1'b0);
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_gnt", gnt, 4'b0000);
        check("rst_tx_data_out", tx_data_out, 8'h00);
        check("rst_timeout_err", timeout_err, 1'b0);

        // Single requester 2.
        rst = 1'b1;
        req_data = 32'h44A5_2211;
        req = 4'b0100;
        cycle();
        check("single_tx_start", tx_start, 1'b1);
        check("single_gnt", gnt, 4'b0100);
        check("single_data", tx_data_out, 8'hA5);
        req = '0;
        wait_idle("single_idle", 50);

        // All requesters held: fair rotation from requester 0.
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        req = 4'b1111;
        req_data = 32'h1312_1110;
        order = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        for (int c = 0; c < 400 && seen.size() < 5; c++) begin
            cycle();
            if (tx_start === 1'b1) seen.push_back(tx_data_out);
        end
        check("rr_launch_count", seen.size(), 5);
        for (int i = 0; i < 5 && i < seen.size(); i++) check("rr_order", seen[i], order[i]);
        req = '0;
        wait_idle("rr_idle", 50);

        // done_tx held five cycles, then tx_active lingers two more.
        x_mode = 2;
        req = 4'b0010;
        wait_launch("held_launch");
        req = '0;
        starts = 1;
        d = 0;
        while (busy !== 1'b0 && d < 40) begin
            cycle();
            d++;
            if (tx_start === 1'b1) starts++;
        end
        check("held_single_start", starts, 1);
        check("held_drain_cycles", d, 9);

        // Reset while waiting on a dead transmitter.
        x_mode = 1;
        req = 4'b0010;
        wait_launch("abort_launch");
        req = '0;
        repeat (2) cycle();
        check("abort_busy_before", busy, 1'b1);
        rst = 1'b0;
        xmt_clear();
        cycle();
        check("abort_busy", busy, 1'b0);
        check("abort_data", tx_data_out, 8'h00);
        check("abort_gnt", gnt, 4'b0000);
        rst = 1'b1;
        x_mode = 0;
        req = 4'b1001;
        cycle();
        check("abort_regrant", gnt, 4'b0001);
        req = '0;
        wait_idle("abort_idle", 50);

        // Transmitter never completes.
        x_mode = 1;
        req = 4'b0001;
        wait_launch("hang_launch");
        req = '0;
`ifdef UART_SCHED_TIMEOUT_EN
        d = 0; pulses = 0; first = -1;
        while (busy !== 1'b0 && d < 60) begin
            cycle();
            d++;
            if (timeout_err === 1'b1) begin
                pulses++;
                if (first < 0) first = d;
            end
        end
        check("wd_pulses", pulses, 1);
        check("wd_pulse_cycle", first, T + 1);
        check("wd_idle", busy, 1'b0);
`else
        hi = 0; to = 0;
        repeat (1000) begin
            cycle();
            if (busy === 1'b1) hi++;
            if (timeout_err !== 1'b0) to++;
        end
        check("hang_busy_cycles", hi, 1000);
        check("hang_timeout_seen", to, 0);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
`endif
        x_mode = 0;

        // Random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(299, 0) == 0) begin
                rst = 1'b0;
                xmt_clear();
            end else begin
                rst = 1'b1;
            end
            if ($urandom_range(3, 0) == 0) begin
                nr = N'($urandom);
                if ($urandom_range(4, 0) == 0) nr = '0;
                for (int i = 0; i < N; i++)
                    if (!nr[i] && !req[i]) req_data[8*i +: 8] = 8'($urandom);
                req = nr;
            end
            cycle();
        end
        rst = 1'b1;
        req = '0;
        wait_idle("final_idle", 60);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL sim_time_limit: got timeout, expected completion");
        $fatal(1, "time limit exceeded");
    end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning number of byte requesters sharing one uart_tx transmitter (legal 2..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 20000, meaning the done_tx watchdog limit in clk cycles (used only with UART_SCHED_TIMEOUT_EN).
REQ-003 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-low.
REQ-005 Port req, input, NUM_REQ: per-requester byte-pending request, level.
REQ-006 Port req_data, input, 8*NUM_REQ: byte of requester i on bits [8i+7:8i], stable while req[i]=1.
REQ-007 Port gnt, output, NUM_REQ: one-hot, one-cycle pulse, byte of requester i accepted.
REQ-008 Port tx_start, output, 1: start pulse to the transmitter.
REQ-009 Port tx_data_out, output, 8: byte to the transmitter's tx_data_in.
REQ-010 Port tx_active, input, 1: transmitter busy, from the transmitter.
REQ-011 Port done_tx, input, 1: transmitter frame complete, from the transmitter.
REQ-012 Port busy, output, 1: high in every state except IDLE.
REQ-013 Port timeout_err, output, 1: one-cycle watchdog-expiry pulse.

Function
REQ-014 The FSM SHALL have states IDLE, LAUNCH, WAIT_DONE and DRAIN.
REQ-015 IDLE with req!=0 at a clock edge SHALL select a winner, register its byte into tx_data_out and go to LAUNCH; IDLE with req=0 SHALL stay.
REQ-016 Winner selection SHALL be round-robin: first set req bit searching upward from (last_winner+1) mod NUM_REQ, wrapping.
REQ-017 In LAUNCH, for exactly one cycle, tx_start=1 and gnt[winner]=1; next state is WAIT_DONE; latency from req sampled to tx_start is 1 cycle.
REQ-018 tx_data_out SHALL hold the launched byte from LAUNCH until the next LAUNCH.
REQ-019 WAIT_DONE SHALL go to DRAIN when done_tx=1; last_winner SHALL update to the winner on that transition.
REQ-020 DRAIN SHALL go to IDLE on the first cycle with done_tx=0 and tx_active=0, so a held done_tx never launches twice.
REQ-021 req changes outside IDLE SHALL be ignored; a requester still asserting req after its gnt SHALL be rearbitrated as a new byte.
REQ-022 tx_start and gnt SHALL never be high outside LAUNCH; gnt SHALL be zero or one-hot.
REQ-023 With all NUM_REQ requesters continuously asserting, grants SHALL cycle 0,1,..,NUM_REQ-1,0 with no starvation.

Reset
REQ-024 rst=0 at a clock edge SHALL force state IDLE, tx_start=0, gnt=0, tx_data_out=8'h00, busy=0, timeout_err=0, last_winner=NUM_REQ-1 (requester 0 has first priority), watchdog=0.
REQ-025 Reset mid-frame SHALL abort without waiting for done_tx; no gnt SHALL be issued for the aborted state.

Configuration
REQ-026 With UART_SCHED_TIMEOUT_EN defined, a counter SHALL clear on entering WAIT_DONE, increment each WAIT_DONE cycle, and on reaching TIMEOUT_CYCLES pulse timeout_err for one cycle and go to DRAIN with last_winner updated.
REQ-027 Without UART_SCHED_TIMEOUT_EN, no counter SHALL be built, timeout_err SHALL be tied 0 and WAIT_DONE waits indefinitely.

Structure
REQ-028 Package uart_pkg SHALL hold the FSM state enum, default NUM_REQ and default TIMEOUT_CYCLES.
REQ-029 Winner selection SHALL be a combinational sub-module uart_rr_arbiter (inputs req, last_winner; outputs one-hot pick, index, any).

Verification
REQ-030 Single req[2]=1, req_data byte2=8'hA5 in IDLE -> next cycle tx_start=1, gnt=4'b0100, tx_data_out=8'hA5; after done_tx, busy=0.
REQ-031 req=4'b1111 held, bytes 8'h10..8'h13 -> launches in order 8'h10,8'h11,8'h12,8'h13,8'h10.
REQ-032 done_tx held high 5 cycles -> exactly one tx_start; DRAIN exits only after done_tx=0 and tx_active=0.
REQ-033 rst=0 asserted during WAIT_DONE -> next cycle busy=0, tx_data_out=8'h00; req=4'b1001 afterwards -> gnt=4'b0001 first.
REQ-034 UART_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16, done_tx never asserted -> timeout_err pulse exactly 16 cycles after WAIT_DONE entry, then IDLE.
REQ-035 Without the macro, same stimulus -> timeout_err stays 0, busy stays 1 for 1000 cycles.
